// File: rtl/sprite_compositor.sv
// Sprite compositor: overlays NUM_SPRITES hardware sprites on a background RGB stream
// through a fixed 4-edge pipeline with external per-channel pattern ROMs and a shared palette.
module sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int SIZE_LOG2   = 5,
  parameter int FRAME_W     = 3,
  parameter int IDX_W       = 4,
  parameter int ROM_AW      = FRAME_W + 2*SIZE_LOG2,
  parameter int SEL_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    hcount,
  input  logic [9:0]                    vcount,
  input  logic                          pix_valid,
  input  logic [23:0]                   bg_rgb,
  input  logic                          frame_start,
  input  logic                          reg_we,
  input  logic [SEL_W-1:0]              reg_sel,
  input  logic [1:0]                    reg_field,
  input  logic [9:0]                    reg_wdata,
  input  logic                          pal_we,
  input  logic [IDX_W-1:0]              pal_addr,
  input  logic [23:0]                   pal_wdata,
  output logic [NUM_SPRITES*ROM_AW-1:0] rom_addr,
  input  logic [NUM_SPRITES*IDX_W-1:0]  rom_data,
  output logic [7:0]                    red,
  output logic [7:0]                    green,
  output logic [7:0]                    blue,
  output logic                          out_valid,
  output logic [NUM_SPRITES-1:0]        collision,
  input  logic                          coll_clear
);

  localparam int ATTR_W = FRAME_W + 4;
  localparam int PAL_N  = 1 << IDX_W;
  localparam int TEX    = 1 << SIZE_LOG2;

  // attr layout: {enable, hflip, vflip, scale2x, frame}
  localparam int A_EN = ATTR_W - 1;
  localparam int A_HF = ATTR_W - 2;
  localparam int A_VF = ATTR_W - 3;
  localparam int A_S2 = FRAME_W;

  logic [9:0]        sh_hpos [NUM_SPRITES];
  logic [9:0]        sh_vpos [NUM_SPRITES];
  logic [ATTR_W-1:0] sh_attr [NUM_SPRITES];
  logic [9:0]        ac_hpos [NUM_SPRITES];
  logic [9:0]        ac_vpos [NUM_SPRITES];
  logic [ATTR_W-1:0] ac_attr [NUM_SPRITES];
  logic [23:0]       palette [PAL_N];

  logic unused_wdata;
  assign unused_wdata = ^reg_wdata[9:ATTR_W];

  // Active copy reads shadow before this edge's write lands, so a coincident write waits a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        sh_hpos[i] <= '0;
        sh_vpos[i] <= '0;
        sh_attr[i] <= '0;
        ac_hpos[i] <= '0;
        ac_vpos[i] <= '0;
        ac_attr[i] <= '0;
      end
    end else begin
      if (frame_start) begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
          ac_hpos[i] <= sh_hpos[i];
          ac_vpos[i] <= sh_vpos[i];
          ac_attr[i] <= sh_attr[i];
        end
      end
      if (reg_we) begin
        case (reg_field)
          2'd0:    sh_hpos[reg_sel] <= reg_wdata;
          2'd1:    sh_vpos[reg_sel] <= reg_wdata;
          2'd2:    sh_attr[reg_sel] <= reg_wdata[ATTR_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PAL_N; i++) palette[i] <= '0;
    end else if (pal_we) begin
      palette[pal_addr] <= pal_wdata;
    end
  end

  // E1: hit test and texel address
  logic [10:0]          w_c    [NUM_SPRITES];
  logic [10:0]          dx_c   [NUM_SPRITES];
  logic [10:0]          dy_c   [NUM_SPRITES];
  logic [SIZE_LOG2-1:0] u_c    [NUM_SPRITES];
  logic [SIZE_LOG2-1:0] v_c    [NUM_SPRITES];
  logic [ROM_AW-1:0]    addr_c [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit_c;

  always_comb begin
    hit_c = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      w_c[i]  = ac_attr[i][A_S2] ? 11'(2*TEX) : 11'(TEX);
      dx_c[i] = {1'b0, hcount} - {1'b0, ac_hpos[i]};
      dy_c[i] = {1'b0, vcount} - {1'b0, ac_vpos[i]};
      hit_c[i] = ac_attr[i][A_EN]
              && ({1'b0, hcount} >= {1'b0, ac_hpos[i]})
              && ({1'b0, hcount} <  ({1'b0, ac_hpos[i]} + w_c[i]))
              && ({1'b0, vcount} >= {1'b0, ac_vpos[i]})
              && ({1'b0, vcount} <  ({1'b0, ac_vpos[i]} + w_c[i]));
      u_c[i] = ac_attr[i][A_S2] ? SIZE_LOG2'(dx_c[i] >> 1) : SIZE_LOG2'(dx_c[i]);
      v_c[i] = ac_attr[i][A_S2] ? SIZE_LOG2'(dy_c[i] >> 1) : SIZE_LOG2'(dy_c[i]);
      if (ac_attr[i][A_HF]) u_c[i] = ~u_c[i];
      if (ac_attr[i][A_VF]) v_c[i] = ~v_c[i];
      addr_c[i] = {ac_attr[i][FRAME_W-1:0], v_c[i], u_c[i]};
    end
  end

  logic [NUM_SPRITES-1:0] hit1, hit2;
  logic [23:0]            bg1, bg2, bg3;
  logic                   pv1, pv2, pv3;
  logic [IDX_W-1:0]       idx3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      hit1     <= '0;
      bg1      <= '0;
      pv1      <= 1'b0;
      hit2     <= '0;
      bg2      <= '0;
      pv2      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++)
        rom_addr[i*ROM_AW +: ROM_AW] <= addr_c[i];
      hit1 <= hit_c;
      bg1  <= bg_rgb;
      pv1  <= pix_valid;
      hit2 <= hit1;
      bg2  <= bg1;
      pv2  <= pv1;
    end
  end

  // E3: priority resolve and collision; rom_data is valid after E2
  logic [NUM_SPRITES-1:0] opaque_c;
  logic [IDX_W-1:0]       win_idx_c;
  logic                   found_c;
  logic                   multi_c;

  always_comb begin
    opaque_c  = '0;
    win_idx_c = '0;
    found_c   = 1'b0;
    multi_c   = 1'b0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      opaque_c[i] = hit2[i] && (rom_data[i*IDX_W +: IDX_W] != '0);
      if (opaque_c[i]) begin
        if (!found_c) begin
          win_idx_c = rom_data[i*IDX_W +: IDX_W];
          found_c   = 1'b1;
        end else begin
          multi_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx3      <= '0;
      bg3       <= '0;
      pv3       <= 1'b0;
      collision <= '0;
    end else begin
      idx3      <= win_idx_c;
      bg3       <= bg2;
      pv3       <= pv2;
      collision <= (coll_clear ? '0 : collision) | (multi_c ? opaque_c : '0);
    end
  end

  // E4: final colour select; index 0 means no opaque sprite
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {red, green, blue} <= '0;
      out_valid          <= 1'b0;
    end else begin
      if (!pv3)
        {red, green, blue} <= '0;
      else if (idx3 != '0)
        {red, green, blue} <= palette[idx3];
      else
        {red, green, blue} <= bg3;
      out_valid <= pv3;
    end
  end

endmodule
